// File: rtl/filterbank_pkg.sv
// Shared types, constants and helpers for the time-multiplexed vocoder filterbank.
// Rows 0..2 of BAND_COEFS are simple gains/recursions; rows 3..15 are resonant bandpass sections.
package filterbank_pkg;

    localparam int unsigned MAX_BANDS = 16;
    localparam int unsigned CoefBits  = 18;

    typedef logic signed [CoefBits-1:0] coef_t;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StWrite,
        StDone
    } state_t;

    // Order per row: b0, b1, b2, a1, a2 (Q2.16); the datapath subtracts the a-terms.
    localparam coef_t BAND_COEFS [MAX_BANDS][5] = '{
        '{18'sd32768, 18'sd0, 18'sd0, 18'sd0, 18'sd0},
        '{18'sd65536, 18'sd0, 18'sd0, -18'sd32768, 18'sd0},
        '{18'sd131071, 18'sd0, 18'sd0, 18'sd0, 18'sd0},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd124000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd118000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd110000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd100000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd88000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd74000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd58000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd40000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, -18'sd20000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, 18'sd0, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, 18'sd20000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, 18'sd40000, 18'sd58982},
        '{18'sd3000, 18'sd0, -18'sd3000, 18'sd60000, 18'sd58982}
    };

    // Clamp a value to the signed range of a 'width'-bit word; caller truncates the result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// One multiply-accumulate lane of the shared biquad datapath: clear/add/subtract per cycle,
// result is the accumulator shifted down by the coefficient fraction and saturated.
module biquad_mac
    import filterbank_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned COEF_WIDTH = 18,
    parameter int unsigned COEF_FRAC  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clear,
    input  logic                         sub,
    input  logic signed [WIDTH-1:0]      sample,
    input  logic signed [COEF_WIDTH-1:0] coef,
    output logic signed [WIDTH-1:0]      result
);

    localparam int unsigned ProdW = WIDTH + COEF_WIDTH;
    localparam int unsigned AccW  = ProdW + 3;

    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0]  prod_ext;
    logic signed [AccW-1:0]  acc_base;
    logic signed [AccW-1:0]  acc_d;
    logic signed [AccW-1:0]  acc_q;
    logic signed [AccW-1:0]  acc_shr;

    assign prod     = ProdW'(sample) * ProdW'(coef);
    assign prod_ext = AccW'(prod);
    assign acc_base = clear ? '0 : acc_q;
    assign acc_d    = sub ? acc_base - prod_ext : acc_base + prod_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
        end
    end

    assign acc_shr = acc_q >>> COEF_FRAC;
    assign result  = WIDTH'(saturate(64'(acc_shr), WIDTH));

endmodule

// File: rtl/filterbank_tdm.sv
// Time-multiplexed carrier/modulator filterbank with per-band modulator envelope follower.
// Define FILTERBANK_COEF_WR_EN to replace the constant coefficient table with a writable one.
module filterbank_tdm
    import filterbank_pkg::*;
#(
    parameter int unsigned NUM_BANDS  = 16,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned COEF_WIDTH = 18,
    parameter int unsigned COEF_FRAC  = 16,
    parameter int unsigned ENV_SHIFT  = 6
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         valid_in,
    input  logic signed [WIDTH-1:0]      carrier_sample_in,
    input  logic signed [WIDTH-1:0]      modulator_sample_in,
`ifdef FILTERBANK_COEF_WR_EN
    input  logic                         coef_we_in,
    input  logic [$clog2(MAX_BANDS*5)-1:0] coef_addr_in,
    input  logic signed [COEF_WIDTH-1:0] coef_data_in,
`endif
    output logic signed [WIDTH-1:0]      carrier_out [NUM_BANDS],
    output logic signed [WIDTH-1:0]      envelope_out [NUM_BANDS],
    output logic                         valid_out,
    output logic                         busy_out,
    output logic                         overrun_out
);

    localparam int unsigned BandW = $clog2(MAX_BANDS);
    localparam logic signed [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MaxVal = ~MinVal;

    state_t             state_q;
    logic [BandW-1:0]   band_q;
    logic [2:0]         k_q;
    logic               valid_q, busy_q, overrun_q;
    logic signed [WIDTH-1:0] x_car_q, x_mod_q;
    logic signed [WIDTH-1:0] car_x1_q [NUM_BANDS], car_x2_q [NUM_BANDS];
    logic signed [WIDTH-1:0] car_y1_q [NUM_BANDS], car_y2_q [NUM_BANDS];
    logic signed [WIDTH-1:0] mod_x1_q [NUM_BANDS], mod_x2_q [NUM_BANDS];
    logic signed [WIDTH-1:0] mod_y1_q [NUM_BANDS], mod_y2_q [NUM_BANDS];
    logic signed [WIDTH-1:0] env_q [NUM_BANDS];

    logic signed [WIDTH-1:0]      car_op, mod_op, car_y, mod_y;
    logic signed [COEF_WIDTH-1:0] coef;
    logic signed [WIDTH-1:0]      mod_abs, env_cur, env_new;
    logic signed [WIDTH:0]        env_diff, env_sum;

`ifdef FILTERBANK_COEF_WR_EN
    localparam int unsigned AddrW = $clog2(MAX_BANDS*5);
    coef_t            coef_q [MAX_BANDS*5];
    logic [AddrW-1:0] coef_idx;

    assign coef_idx = AddrW'(band_q) * AddrW'(5) + AddrW'(k_q);
    assign coef     = COEF_WIDTH'(coef_q[coef_idx]);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int b = 0; b < MAX_BANDS; b++) begin
                for (int k = 0; k < 5; k++) begin
                    coef_q[b*5+k] <= BAND_COEFS[b][k];
                end
            end
        end else if (coef_we_in && !busy_q && (32'(coef_addr_in) < NUM_BANDS*5)) begin
            coef_q[coef_addr_in] <= coef_t'(coef_data_in);
        end
    end
`else
    assign coef = COEF_WIDTH'(BAND_COEFS[band_q][k_q]);
`endif

    always_comb begin
        car_op = x_car_q;
        mod_op = x_mod_q;
        case (k_q)
            3'd1:    begin car_op = car_x1_q[band_q]; mod_op = mod_x1_q[band_q]; end
            3'd2:    begin car_op = car_x2_q[band_q]; mod_op = mod_x2_q[band_q]; end
            3'd3:    begin car_op = car_y1_q[band_q]; mod_op = mod_y1_q[band_q]; end
            3'd4:    begin car_op = car_y2_q[band_q]; mod_op = mod_y2_q[band_q]; end
            default: ;
        endcase
    end

    biquad_mac #(
        .WIDTH      (WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .COEF_FRAC  (COEF_FRAC)
    ) u_mac_car (
        .clk    (clk_in),
        .rst    (rst_in),
        .en     (state_q == StMac),
        .clear  (k_q == 3'd0),
        .sub    (k_q >= 3'd3),
        .sample (car_op),
        .coef   (coef),
        .result (car_y)
    );

    biquad_mac #(
        .WIDTH      (WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .COEF_FRAC  (COEF_FRAC)
    ) u_mac_mod (
        .clk    (clk_in),
        .rst    (rst_in),
        .en     (state_q == StMac),
        .clear  (k_q == 3'd0),
        .sub    (k_q >= 3'd3),
        .sample (mod_op),
        .coef   (coef),
        .result (mod_y)
    );

    // |y| with the most-negative input clamped so the envelope never wraps negative.
    always_comb begin
        env_cur = env_q[band_q];
        if (!mod_y[WIDTH-1]) begin
            mod_abs = mod_y;
        end else if (mod_y == MinVal) begin
            mod_abs = MaxVal;
        end else begin
            mod_abs = -mod_y;
        end
        env_diff = (WIDTH+1)'(mod_abs) - (WIDTH+1)'(env_cur);
        env_sum  = (WIDTH+1)'(env_cur) + (env_diff >>> ENV_SHIFT);
        env_new  = WIDTH'(env_sum);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            band_q    <= '0;
            k_q       <= '0;
            x_car_q   <= '0;
            x_mod_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                car_x1_q[b] <= '0;
                car_x2_q[b] <= '0;
                car_y1_q[b] <= '0;
                car_y2_q[b] <= '0;
                mod_x1_q[b] <= '0;
                mod_x2_q[b] <= '0;
                mod_y1_q[b] <= '0;
                mod_y2_q[b] <= '0;
                env_q[b]    <= '0;
            end
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= valid_in && busy_q;
            unique case (state_q)
                StIdle, StDone: begin
                    if (valid_in) begin
                        x_car_q <= carrier_sample_in;
                        x_mod_q <= modulator_sample_in;
                        band_q  <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StMac;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StMac: begin
                    if (k_q == 3'd4) begin
                        k_q     <= '0;
                        state_q <= StWrite;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                StWrite: begin
                    car_x2_q[band_q] <= car_x1_q[band_q];
                    car_x1_q[band_q] <= x_car_q;
                    car_y2_q[band_q] <= car_y1_q[band_q];
                    car_y1_q[band_q] <= car_y;
                    mod_x2_q[band_q] <= mod_x1_q[band_q];
                    mod_x1_q[band_q] <= x_mod_q;
                    mod_y2_q[band_q] <= mod_y1_q[band_q];
                    mod_y1_q[band_q] <= mod_y;
                    env_q[band_q]    <= env_new;
                    if (band_q == BandW'(NUM_BANDS - 1)) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        band_q  <= band_q + BandW'(1);
                        state_q <= StMac;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The carrier y1 history doubles as the published carrier output.
    assign carrier_out  = car_y1_q;
    assign envelope_out = env_q;
    assign valid_out    = valid_q;
    assign busy_out     = busy_q;
    assign overrun_out  = overrun_q;

endmodule
